tone_player: RTL and testbench

Beat-timed tone synthesizer; the consuming end of the 4-bit tune-code interface. Each beat, drives a falling edge on `trigger` to request the next note from the tune sequencer, samples the returned `tune_code` after a settle window, then produces a square wave at that note's pitch on `speaker` for the rest of the beat. Sits between the tune sequencer and the board buzzer pin.

---
 rtl/tone_pkg.sv | 51 +++++
 rtl/tone_divider.sv | 44 ++++
 rtl/tone_player.sv | 126 ++++++++++++
 tb/tb_tone_player.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// ============================================================================
// tone_pkg
// Note-code constants, pitch table and FSM state type for tone_player.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tone_pkg;

    localparam int         CODE_NUM_PITCH = 9;
    localparam logic [3:0] CODE_REST_MIN  = 4'd9;
    localparam logic [3:0] CODE_NONE      = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    // Pitch in Hz for each code; rests map to 0.
    function automatic int note_freq(input int code);
        case (code)
            0:       return 196;
            1:       return 220;
            2:       return 247;
            3:       return 262;
            4:       return 294;
            5:       return 330;
            6:       return 392;
            7:       return 440;
            8:       return 523;
            default: return 0;
        endcase
    endfunction

    function automatic int half_period(input int clk_hz, input int code);
        int f;
        f = note_freq(code);
        return (f == 0) ? 0 : clk_hz / (2 * f);
    endfunction

    // The lowest pitch (code 0) has the longest half-period.
    function automatic int max_half(input int clk_hz);
        return half_period(clk_hz, 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tone_divider.sv
// ============================================================================
// tone_divider
// Loadable half-period counter toggling a square-wave output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tone_divider #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hold,
    input  logic [WIDTH-1:0] half,
    output logic             speaker
);

    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;

    // A zero period (rest) leaves the output parked low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period  <= '0;
            count   <= '0;
            speaker <= 1'b0;
        end else if (clear) begin
            period  <= half;
            count   <= '0;
            speaker <= 1'b0;
        end else if (!hold && period != '0) begin
            if (count == period - WIDTH'(1)) begin
                count   <= '0;
                speaker <= ~speaker;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tone_player.sv
// ============================================================================
// tone_player
// Beat-timed tone synthesizer: requests a note per beat, latches it, plays it.
// Optional silent articulation tail per beat: define TONE_ARTIC_GAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tone_player
    import tone_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int BEAT_CYCLES     = 12_500_000,
    parameter int TRIG_LOW_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 8,
    parameter int GAP_CYCLES      = 1_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] tune_code,
    output logic       trigger,
    output logic       speaker,
    output logic [3:0] note,
    output logic       note_valid
);

    localparam int            BW        = $clog2(BEAT_CYCLES);
    localparam int            DW        = $clog2(max_half(CLK_HZ)) + 1;
    localparam logic [BW-1:0] TRIG_LAST = BW'(TRIG_LOW_CYCLES - 1);
    localparam logic [BW-1:0] LATCH_AT  = BW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] GAP_AT    = BW'(BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
`ifdef TONE_ARTIC_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    state_t          state;
    state_t          state_nx;
    logic [BW-1:0]   beat_cnt;
    logic [DW-1:0]   half_tbl [CODE_NUM_PITCH];
    logic [DW-1:0]   div_half;
    logic            beat_end;
    logic            latch;
    logic            div_clear;
    logic            div_hold;
    logic            tone_out;

    for (genvar i = 0; i < CODE_NUM_PITCH; i++) begin : g_half_tbl
        localparam int HP = half_period(CLK_HZ, i);
        assign half_tbl[i] = DW'(HP);
    end

    assign beat_end = (beat_cnt == BEAT_LAST);

    // Load the incoming code at the latch; otherwise track the held note.
    always_comb begin
        div_half = '0;
        if (latch) begin
            if (tune_code < CODE_REST_MIN) div_half = half_tbl[tune_code];
        end else if (note < CODE_REST_MIN) begin
            div_half = half_tbl[note];
        end
    end

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        case (state)
            ST_IDLE:   if (en) state_nx = ST_REQ;
            ST_REQ:    if (beat_cnt == TRIG_LAST) state_nx = ST_SETTLE;
            ST_SETTLE: begin
                if (beat_cnt == LATCH_AT) begin
                    state_nx = ST_PLAY;
                    latch    = 1'b1;
                end
            end
            ST_PLAY: begin
                if (beat_end)                          state_nx = en ? ST_REQ : ST_IDLE;
                else if (GAP_EN && beat_cnt == GAP_AT) state_nx = ST_GAP;
            end
            ST_GAP:    if (beat_end) state_nx = en ? ST_REQ : ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            note       <= CODE_NONE;
            note_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE || beat_end) beat_cnt <= '0;
            else                              beat_cnt <= beat_cnt + BW'(1);
            if (latch) begin
                note       <= tune_code;
                note_valid <= (tune_code < CODE_REST_MIN);
            end
        end
    end

    // Clearing on the IDLE-entry edge makes the speaker low in the first IDLE cycle.
    assign div_clear = (state == ST_IDLE) || latch || (beat_end && !en);
    assign div_hold  = (state == ST_GAP);

    tone_divider #(
        .WIDTH (DW)
    ) u_divider (
        .clk     (clk),
        .rst     (rst),
        .clear   (div_clear),
        .hold    (div_hold),
        .half    (div_half),
        .speaker (tone_out)
    );

    assign trigger = (state != ST_REQ);
    assign speaker = tone_out && (state != ST_GAP);

endmodule

`default_nettype wire

// File: tb/tb_tone_player.sv
// ============================================================================
// tb_tone_player
// Scoreboard bench: expected output changes and snapshots are queued with
// their cycle numbers; a negedge monitor compares what the DUT presents.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tone_player;

    localparam int K_TRIG = 0;
    localparam int K_NOTE = 1;
    localparam int K_SPK  = 2;
`ifdef TONE_ARTIC_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } evt_t;

    evt_t evq[$];
    evt_t snq[$];
    evt_t me;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] tune_code = 4'd0;
    logic       trigger;
    logic       speaker;
    logic [3:0] note;
    logic       note_valid;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_on = 1'b0;
    logic p_trig = 1'b1;
    logic p_spk = 1'b0;
    logic [4:0] p_note = 5'h0F;

    tone_player #(
        .CLK_HZ          (1_000_000),
        .BEAT_CYCLES     (20000),
        .TRIG_LOW_CYCLES (4),
        .SETTLE_CYCLES   (8),
        .GAP_CYCLES      (2000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tune_code  (tune_code),
        .trigger    (trigger),
        .speaker    (speaker),
        .note       (note),
        .note_valid (note_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_TRIG:  return "trigger";
            K_NOTE:  return "note";
            default: return "speaker";
        endcase
    endfunction

    task automatic push(input int c, input int k, input logic [7:0] v);
        evt_t e;
        e.cyc = c; e.kind = k; e.val = v;
        evq.push_back(e);
    endtask

    task automatic snap(input int c, input logic t, input logic s, input logic nv, input logic [3:0] n);
        evt_t e;
        e.cyc = c; e.kind = -1; e.val = {1'b0, t, s, nv, n};
        snq.push_back(e);
    endtask

    task automatic see(input int k, input logic [7:0] v);
        evt_t e;
        checks++;
        if (evq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s cyc=%0d actual=%h required=no_change", kname(k), cyc, v);
        end else begin
            e = evq.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val !== v)
                begin
                failures++;
                $display("FAIL %s_event actual=%s@%0d val=%h required=%s@%0d val=%h",
                         kname(e.kind), kname(k), cyc, v, kname(e.kind), e.cyc, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (trigger !== p_trig) begin
                see(K_TRIG, {7'b0, trigger});
                p_trig = trigger;
            end
            if ({note_valid, note} !== p_note) begin
                see(K_NOTE, {3'b0, note_valid, note});
                p_note = {note_valid, note};
            end
            if (speaker !== p_spk) begin
                see(K_SPK, {7'b0, speaker});
                p_spk = speaker;
            end
            while (snq.size() > 0 && snq[0].cyc <= cyc) begin
                me = snq.pop_front();
                checks++;
                if (me.cyc != cyc || {1'b0, trigger, speaker, note_valid, note} !== me.val) begin
                    failures++;
                    $display("FAIL snapshot cyc=%0d actual={trig,spk,nv,note}=%h required=%h",
                             me.cyc, {1'b0, trigger, speaker, note_valid, note}, me.val);
                end
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                me = evq.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_%s actual=no_change required=%h@%0d", kname(me.kind), me.val, me.cyc);
            end
        end
    end

    // Drive inputs 2 time units after posedge n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    // Trigger pulse and latch of a beat starting at edge f; lvl is the raw tone level.
    task automatic head(input int f, input logic [3:0] code, inout logic lvl);
        push(f, K_TRIG, 8'd0);
        if (GAP_ON && lvl) push(f, K_SPK, 8'd1);
        push(f + 4, K_TRIG, 8'd1);
        push(f + 8, K_NOTE, {3'b0, (code < 4'd9), code});
        if (lvl) push(f + 8, K_SPK, 8'd0);
        lvl = 1'b0;
    endtask

    task automatic tone(input int start, input int half, input int lim, inout logic lvl);
        for (int k = 1; half > 0 && start + k * half < lim; k++) begin
            lvl = ~lvl;
            push(start + k * half, K_SPK, {7'b0, lvl});
        end
    endtask

    task automatic gap_tail(input int f, input logic lvl);
        if (GAP_ON && lvl) push(f + 18000, K_SPK, 8'd0);
    endtask

    initial begin
        logic lvl;
        int   f1, f2, f3, f5;
        lvl = 1'b0;

        // Reset with en high, then 100 idle clocks with en low.
        en = 1'b1;
        tune_code = 4'd7;
        #1 rst = 1'b0;
        #1 mon_on = 1'b1;
        snap(3, 1'b1, 1'b0, 1'b0, 4'hF);
        goto(10);
        rst = 1'b1;
        en  = 1'b0;
        snap(60, 1'b1, 1'b0, 1'b0, 4'hF);
        snap(110, 1'b1, 1'b0, 1'b0, 4'hF);

        // Beat 1: A4, half-period 1136.
        goto(112);
        f1 = 113;
        head(f1, 4'd7, lvl);
        snap(f1 + 2, 1'b0, 1'b0, 1'b0, 4'hF);
        snap(f1 + 5, 1'b1, 1'b0, 1'b0, 4'hF);
        snap(f1 + 9, 1'b1, 1'b0, 1'b1, 4'd7);
        tone(f1 + 8, 1136, GAP_ON ? f1 + 18000 : f1 + 20008, lvl);
        gap_tail(f1, lvl);
        snap(f1 + 19999, 1'b1, GAP_ON ? 1'b0 : 1'b1, 1'b1, 4'd7);
        en = 1'b1;

        // Beat 2: C4, half-period 1908.
        goto(f1 + 100);
        tune_code = 4'd3;
        f2 = f1 + 20000;
        head(f2, 4'd3, lvl);
        tone(f2 + 8, 1908, GAP_ON ? f2 + 18000 : f2 + 20008, lvl);
        gap_tail(f2, lvl);

        // Beat 3: rest code, en dropped at count 5000, then IDLE.
        goto(f2 + 100);
        tune_code = 4'd12;
        f3 = f2 + 20000;
        head(f3, 4'd12, lvl);
        snap(f3 + 10000, 1'b1, 1'b0, 1'b0, 4'hC);
        snap(f3 + 19999, 1'b1, 1'b0, 1'b0, 4'hC);
        snap(f3 + 20000, 1'b1, 1'b0, 1'b0, 4'hC);
        snap(f3 + 20100, 1'b1, 1'b0, 1'b0, 4'hC);
        goto(f3 + 5000);
        en = 1'b0;

        // Beat 5: G4 (half-period 1275), reset asserted at count 9000.
        goto(f3 + 20200);
        tune_code = 4'd6;
        en = 1'b1;
        f5 = f3 + 20201;
        head(f5, 4'd6, lvl);
        tone(f5 + 8, 1275, f5 + 9001, lvl);
        push(f5 + 9000, K_NOTE, 8'h0F);
        if (lvl) push(f5 + 9000, K_SPK, 8'd0);
        lvl = 1'b0;
        snap(f5 + 9000, 1'b1, 1'b0, 1'b0, 4'hF);
        goto(f5 + 9000);
        rst = 1'b0;
        goto(f5 + 9010);
        rst = 1'b1;
        en  = 1'b0;
        goto(f5 + 9060);
        mon_on = 1'b0;

        checks++;
        if (evq.size() != 0 || snq.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d/%0d pending required=0/0", evq.size(), snq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
